// File: rtl/voice_osc_pkg.sv
// voice_osc_pkg
// Shared widths, default parameters and elaboration-time table builders for
// the time-multiplexed sine oscillator (voice_osc_pipe).
//   tuning_word(midi, fs_hz) : 16-bit phase increment for a MIDI note
//   quarter_sine(idx, qbits) : unsigned magnitude of one quarter-wave entry
package voice_osc_pkg;

  localparam int DEF_NBANKS    = 10;
  localparam int DEF_FS_HZ     = 48000;
  localparam int DEF_QLUT_BITS = 8;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 24;
  localparam int MIDI_W   = 7;
  localparam int MAG_W    = SAMPLE_W - 1;

  localparam real FULL_SCALE = 8388607.0;
  localparam real PI         = 3.14159265358979323846;

  // Phase increment per sample so that 2^16 counts equal one period of the
  // equal-tempered note frequency (A4 = note 69 = 440 Hz). Only evaluated at
  // elaboration time to build the tuning table.
  function automatic logic [PHASE_W-1:0] tuning_word(input int midi, input int fs_hz);
    real freq;
    real step;
    freq = 440.0 * (2.0 ** ((real'(midi) - 69.0) / 12.0));
    step = freq * 65536.0 / real'(fs_hz);
    return PHASE_W'($rtoi(step + 0.5));
  endfunction

  // Quarter-wave sample taken at the centre of each address bucket. The half
  // bucket offset keeps every entry strictly positive and below full scale,
  // so the symmetry logic can negate without overflow.
  function automatic logic [MAG_W-1:0] quarter_sine(input int idx, input int qbits);
    real angle;
    real mag;
    angle = (PI / 2.0) * (real'(idx) + 0.5) / real'(1 << qbits);
    mag   = FULL_SCALE * $sin(angle);
    return MAG_W'($rtoi(mag + 0.5));
  endfunction

endpackage

// File: rtl/voice_osc_pipe_rom.sv
// quarter_sine_rom
// Synchronous quarter-wave sine ROM. Contents are computed at elaboration
// from voice_osc_pkg::quarter_sine. The output register advances only with
// en so the ROM stays in lock-step with the clk_en-gated pipeline.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : read enable (pipeline advance)
//   addr       : quarter-wave address, QLUT_BITS wide
//   data       : unsigned 23-bit magnitude, registered
module quarter_sine_rom
  import voice_osc_pkg::*;
#(
  parameter int QLUT_BITS = DEF_QLUT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [QLUT_BITS-1:0] addr,
  output logic [MAG_W-1:0]     data
);

  localparam int DEPTH = 1 << QLUT_BITS;

  logic [MAG_W-1:0] rom [DEPTH];

  // Each entry is a constant folded at elaboration, so the array reduces to
  // a fixed lookup table in synthesis.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = quarter_sine(i, QLUT_BITS);
    assign rom[i] = ENTRY;
  end

  // Registered read; cleared on reset like every other pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/voice_osc_pipe.sv
// voice_osc_pipe
// Time-multiplexed sine oscillator. Every clk_en slot serves one voice in
// round-robin order: the voice's 16-bit phase accumulator is advanced by the
// tuning word of its MIDI note, and the pre-increment phase is converted to a
// signed 24-bit sine sample through a quarter-wave ROM. Total latency from
// i_midi to o_sine/o_valid/o_midi is four clk_en-qualified clock edges.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clk_en     : pipeline advance strobe; every register holds when low
//   i_midi     : note for the current slot, 0 = slot silent
//   o_midi     : note tag aligned with o_sine
//   o_phase    : phase-stage output (pre-increment phase), for observability
//   o_valid    : o_sine carries an active voice sample
//   o_sine     : signed sine sample, full scale +/-(2^23-1)
module voice_osc_pipe
  import voice_osc_pkg::*;
#(
  parameter int NBANKS    = DEF_NBANKS,
  parameter int FS_HZ     = DEF_FS_HZ,
  parameter int QLUT_BITS = DEF_QLUT_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic [MIDI_W-1:0]          i_midi,
  output logic [MIDI_W-1:0]          o_midi,
  output logic [PHASE_W-1:0]         o_phase,
  output logic                       o_valid,
  output logic signed [SAMPLE_W-1:0] o_sine
);

  localparam int SLOT_W   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int NOTES    = 1 << MIDI_W;
  localparam int ADDR_MSB = PHASE_W - 3;

  // Tuning table, one constant per MIDI note. Entry 0 is never selected for
  // accumulation because note 0 means "silent".
  logic [PHASE_W-1:0] tw_table [NOTES];

  for (genvar m = 0; m < NOTES; m++) begin : g_tw
    localparam logic [PHASE_W-1:0] TW_M = tuning_word(m, FS_HZ);
    assign tw_table[m] = TW_M;
  end

  logic [SLOT_W-1:0]  slot;
  logic [PHASE_W-1:0] acc [NBANKS];

  logic [PHASE_W-1:0] p_phase;
  logic [MIDI_W-1:0]  p_midi;
  logic               p_valid;

  logic [1:0]           s1_quad;
  logic [QLUT_BITS-1:0] s1_addr;
  logic [MIDI_W-1:0]    s1_midi;
  logic                 s1_valid;

  logic [QLUT_BITS-1:0] rom_addr;
  logic [MAG_W-1:0]     rom_data;

  logic [1:0]        s2_quad;
  logic [MIDI_W-1:0] s2_midi;
  logic              s2_valid;

  logic signed [SAMPLE_W-1:0] rom_mag;

  // Phase stage. The slot counter follows the bank manager's voice order.
  // A silent slot clears its accumulator so the next note on that slot starts
  // at phase 0; a changed nonzero note just keeps accumulating from the
  // current phase with the new step, which keeps the waveform continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      p_phase <= '0;
      p_midi  <= '0;
      p_valid <= 1'b0;
      for (int k = 0; k < NBANKS; k++) begin
        acc[k] <= '0;
      end
    end else if (clk_en) begin
      if (slot == SLOT_W'(NBANKS - 1)) begin
        slot <= '0;
      end else begin
        slot <= slot + SLOT_W'(1);
      end
      if (i_midi != '0) begin
        p_phase   <= acc[slot];
        acc[slot] <= acc[slot] + tw_table[i_midi];
        p_midi    <= i_midi;
        p_valid   <= 1'b1;
      end else begin
        p_phase   <= '0;
        acc[slot] <= '0;
        p_midi    <= '0;
        p_valid   <= 1'b0;
      end
    end
  end

  assign o_phase = p_phase;

  // Sine stage 1: split the phase into quadrant and quarter-wave address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_quad  <= '0;
      s1_addr  <= '0;
      s1_midi  <= '0;
      s1_valid <= 1'b0;
    end else if (clk_en) begin
      s1_quad  <= p_phase[PHASE_W-1 -: 2];
      s1_addr  <= p_phase[ADDR_MSB -: QLUT_BITS];
      s1_midi  <= p_midi;
      s1_valid <= p_valid;
    end
  end

  // Odd quadrants walk the quarter wave backwards, so the address is mirrored
  // before the lookup instead of storing a second table.
  assign rom_addr = s1_quad[0] ? ~s1_addr : s1_addr;

  quarter_sine_rom #(
    .QLUT_BITS (QLUT_BITS)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // Sine stage 2: carry quadrant, tag and valid alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_quad  <= '0;
      s2_midi  <= '0;
      s2_valid <= 1'b0;
    end else if (clk_en) begin
      s2_quad  <= s1_quad;
      s2_midi  <= s1_midi;
      s2_valid <= s1_valid;
    end
  end

  assign rom_mag = {1'b0, rom_data};

  // Sine stage 3: the second half of the period is the negated first half.
  // Silent slots are forced to zero so stale ROM data never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sine  <= '0;
      o_midi  <= '0;
      o_valid <= 1'b0;
    end else if (clk_en) begin
      o_midi  <= s2_midi;
      o_valid <= s2_valid;
      if (!s2_valid) begin
        o_sine <= '0;
      end else if (s2_quad[1]) begin
        o_sine <= -rom_mag;
      end else begin
        o_sine <= rom_mag;
      end
    end
  end

endmodule

// File: tb/tb_voice_osc_pipe.sv
// tb_voice_osc_pipe
// Scoreboard bench for voice_osc_pipe. The driver pushes the expected output
// of every enabled slot into queues; a monitor pops and compares after each
// enabled clock edge and checks that outputs hold on disabled edges.
module tb_voice_osc_pipe;

  localparam int NBANKS    = 10;
  localparam int QLUT_BITS = 8;
  localparam int FS_HZ     = 48000;
  localparam real AMP      = 8388607.0;
  localparam real PI       = 3.14159265358979323846;

  typedef struct {
    int midi;
    int valid;
    int sine;
    int phase;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic [6:0]         i_midi;
  logic [6:0]         o_midi;
  logic [15:0]        o_phase;
  logic               o_valid;
  logic signed [23:0] o_sine;

  int errors = 0;
  int checks = 0;

  exp_t out_q[$];
  int   phase_q[$];
  exp_t last_exp;
  int   last_phase;

  int macc [NBANKS];
  int mslot;

  voice_osc_pipe #(
    .NBANKS    (NBANKS),
    .FS_HZ     (FS_HZ),
    .QLUT_BITS (QLUT_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .i_midi  (i_midi),
    .o_midi  (o_midi),
    .o_phase (o_phase),
    .o_valid (o_valid),
    .o_sine  (o_sine)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Equal-tempered note frequency expressed as phase counts per sample.
  function automatic int tw(input int m);
    real f;
    f = 440.0 * (2.0 ** ((real'(m) - 69.0) / 12.0));
    return $rtoi(f * 65536.0 / real'(FS_HZ) + 0.5);
  endfunction

  // Full-period view: the phase is quantised to 4*2^QLUT_BITS buckets and the
  // sine is sampled at the bucket centre.
  function automatic int sine_of(input int ph);
    int  p;
    real v;
    p = ph >> (14 - QLUT_BITS);
    v = AMP * $sin(2.0 * PI * (real'(p) + 0.5) / real'(4 * (1 << QLUT_BITS)));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic clearModel();
    exp_t z;
    z = '{midi: 0, valid: 0, sine: 0, phase: 0};
    out_q.delete();
    phase_q.delete();
    repeat (3) out_q.push_back(z);
    last_exp   = z;
    last_phase = 0;
    mslot      = 0;
    for (int k = 0; k < NBANKS; k++) macc[k] = 0;
  endtask

  task automatic modelStep(input int m);
    exp_t e;
    if (m != 0) begin
      e = '{midi: m, valid: 1, sine: sine_of(macc[mslot]), phase: macc[mslot]};
      macc[mslot] = (macc[mslot] + tw(m)) % 65536;
    end else begin
      e = '{midi: 0, valid: 0, sine: 0, phase: 0};
      macc[mslot] = 0;
    end
    out_q.push_back(e);
    phase_q.push_back(e.phase);
    mslot = (mslot + 1) % NBANKS;
  endtask

  task automatic applyStimulus(input logic en, input int m);
    @(negedge clk);
    clk_en = en;
    i_midi = 7'(m);
    if (en) modelStep(m);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    clearModel();
    repeat (cycles) begin
      clk_en = 1'($urandom);
      i_midi = 7'($urandom);
      @(negedge clk);
    end
    clk_en = 1'b0;
    i_midi = '0;
    rst_n  = 1'b1;
  endtask

  // Monitor: decoupled from the driver, compares once per clock edge.
  logic en_s;
  logic rst_s;
  exp_t e_pop;
  int   ph_pop;

  always @(posedge clk) begin
    en_s  = clk_en;
    rst_s = rst_n;
    #1;
    if (!rst_s) begin
      checkOutput("reset o_valid", int'(o_valid), 0);
      checkOutput("reset o_midi",  int'(o_midi), 0);
      checkOutput("reset o_phase", int'(o_phase), 0);
      checkOutput("reset o_sine",  int'(o_sine), 0);
    end else if (en_s) begin
      if (out_q.size() == 0 || phase_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard underflow: got empty queue, expected an item");
      end else begin
        e_pop  = out_q.pop_front();
        ph_pop = phase_q.pop_front();
        checkOutput("o_valid", int'(o_valid), e_pop.valid);
        checkOutput("o_midi",  int'(o_midi), e_pop.midi);
        checkOutput("o_sine",  int'(o_sine), e_pop.sine);
        checkOutput("o_phase", int'(o_phase), ph_pop);
        last_exp   = e_pop;
        last_phase = ph_pop;
      end
    end else begin
      checkOutput("hold o_valid", int'(o_valid), last_exp.valid);
      checkOutput("hold o_midi",  int'(o_midi), last_exp.midi);
      checkOutput("hold o_sine",  int'(o_sine), last_exp.sine);
      checkOutput("hold o_phase", int'(o_phase), last_phase);
    end
  end

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b0;
    i_midi = '0;
    clearModel();

    doReset(5);

    // Single voice on slot 0 with continuous enable.
    for (int i = 0; i < 5 * NBANKS; i++) applyStimulus(1'b1, (mslot == 0) ? 69 : 0);

    // All slots silent.
    for (int i = 0; i < 2 * NBANKS; i++) applyStimulus(1'b1, 0);

    // Note 60 on slot 3 only, then silence it for one round and restart.
    for (int i = 0; i < 3 * NBANKS; i++) applyStimulus(1'b1, (mslot == 3) ? 60 : 0);
    for (int i = 0; i < NBANKS; i++)     applyStimulus(1'b1, 0);
    for (int i = 0; i < 3 * NBANKS; i++) applyStimulus(1'b1, (mslot == 3) ? 60 : 0);

    // Same single-voice run from reset, enable only every third clock.
    doReset(3);
    for (int i = 0; i < 15 * NBANKS; i++) begin
      applyStimulus(1'b1 ? (i % 3 == 0) : 1'b0, (mslot == 0) ? 69 : 0);
    end

    // Phase-continuous note change on slot 0 plus another voice on slot 5.
    for (int i = 0; i < 4 * NBANKS; i++) applyStimulus(1'b1, (mslot == 0) ? 81 : ((mslot == 5) ? 69 : 0));

    // Highest note on every slot for 200 visits: accumulators wrap often.
    for (int i = 0; i < 200 * NBANKS; i++) applyStimulus(1'b1, 127);

    // Random notes, random silences, random enable.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127)));
    end

    // Reset in the middle of traffic, then more random traffic.
    doReset(4);
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) != 0,
                    ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 127)));
    end

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
